// File: rtl/char_draw_scheduler.sv
// char_draw_scheduler
// Arbitrates two push requesters onto the character stack's single push port.
// On each frame_start it drains the stack in LIFO order and presents every
// entry to the character renderer over a valid/ready handshake.
module char_draw_scheduler #(
    parameter int CHAR_ID_WIDTH = 8,
    parameter int X_WIDTH       = 9,
    parameter int Y_WIDTH       = 9
) (
    input  logic                     clock,
    input  logic                     reset,
    // requester 0
    input  logic                     req0_valid,
    input  logic [CHAR_ID_WIDTH-1:0] req0_char,
    input  logic [X_WIDTH-1:0]       req0_x,
    input  logic [Y_WIDTH-1:0]       req0_y,
    output logic                     req0_ready,
    // requester 1
    input  logic                     req1_valid,
    input  logic [CHAR_ID_WIDTH-1:0] req1_char,
    input  logic [X_WIDTH-1:0]       req1_x,
    input  logic [Y_WIDTH-1:0]       req1_y,
    output logic                     req1_ready,
    // stack buffer
    output logic                     stack_push,
    output logic [CHAR_ID_WIDTH-1:0] stack_char,
    output logic [X_WIDTH-1:0]       stack_x,
    output logic [Y_WIDTH-1:0]       stack_y,
    output logic                     stack_pop,
    input  logic [CHAR_ID_WIDTH-1:0] stack_char_out,
    input  logic [X_WIDTH-1:0]       stack_x_out,
    input  logic [Y_WIDTH-1:0]       stack_y_out,
    input  logic                     stack_empty,
    input  logic                     stack_full,
    // frame and renderer
    input  logic                     frame_start,
    output logic                     draw_valid,
    input  logic                     draw_ready,
    output logic [CHAR_ID_WIDTH-1:0] draw_char,
    output logic [X_WIDTH-1:0]       draw_x,
    output logic [Y_WIDTH-1:0]       draw_y,
    // status
    output logic                     busy,
    output logic                     frame_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic                       r_last_grant;
    logic                       w_grant0;
    logic                       w_grant1;
    logic [CHAR_ID_WIDTH-1:0]   r_draw_char;
    logic [X_WIDTH-1:0]         r_draw_x;
    logic [Y_WIDTH-1:0]         r_draw_y;

    // State register; reset abandons any drain in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic for the drain sequence POP -> WAIT -> OUT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (frame_start && !stack_empty) begin
                    w_state_nxt = ST_POP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_POP: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                if (draw_ready) begin
                    if (stack_empty) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_POP;
                    end
                end else begin
                    w_state_nxt = ST_OUT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Round-robin grant: only while idle and the stack has room.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if ((r_state == ST_IDLE) && !stack_full) begin
            if (req0_valid && req1_valid) begin
                if (r_last_grant) begin
                    w_grant0 = 1'b1;
                end else begin
                    w_grant1 = 1'b1;
                end
            end else if (req0_valid) begin
                w_grant0 = 1'b1;
            end else if (req1_valid) begin
                w_grant1 = 1'b1;
            end else begin
                w_grant0 = 1'b0;
                w_grant1 = 1'b0;
            end
        end else begin
            w_grant0 = 1'b0;
            w_grant1 = 1'b0;
        end
    end

    // Push data mux; driven to zero when nothing is granted.
    always_comb begin
        stack_char = '0;
        stack_x    = '0;
        stack_y    = '0;
        case ({w_grant1, w_grant0})
            2'b01: begin
                stack_char = req0_char;
                stack_x    = req0_x;
                stack_y    = req0_y;
            end
            2'b10: begin
                stack_char = req1_char;
                stack_x    = req1_x;
                stack_y    = req1_y;
            end
            default: begin
                stack_char = '0;
                stack_x    = '0;
                stack_y    = '0;
            end
        endcase
    end

    // Remember the last winner; reset favours requester 0 on the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (w_grant0) begin
            r_last_grant <= 1'b0;
        end else if (w_grant1) begin
            r_last_grant <= 1'b1;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

    // Capture popped entry in WAIT (stack data is valid one cycle after pop).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_draw_char <= '0;
            r_draw_x    <= '0;
            r_draw_y    <= '0;
        end else if (r_state == ST_WAIT) begin
            r_draw_char <= stack_char_out;
            r_draw_x    <= stack_x_out;
            r_draw_y    <= stack_y_out;
        end else begin
            r_draw_char <= r_draw_char;
            r_draw_x    <= r_draw_x;
            r_draw_y    <= r_draw_y;
        end
    end

    // Strobes and status decode straight from the state register, so a
    // push (IDLE only) and a pop (POP only) can never coincide.
    assign req0_ready    = w_grant0;
    assign req1_ready    = w_grant1;
    assign stack_push    = w_grant0 | w_grant1;
    assign stack_pop     = (r_state == ST_POP);
    assign draw_valid    = (r_state == ST_OUT);
    assign draw_char     = r_draw_char;
    assign draw_x        = r_draw_x;
    assign draw_y        = r_draw_y;
    assign busy          = (r_state != ST_IDLE);
    assign frame_overrun = frame_start & (r_state != ST_IDLE);

endmodule

// File: tb/tb_char_draw_scheduler.sv
// Testbench for char_draw_scheduler: behavioural LIFO stack model, a table of
// arbitration vectors, and hand-written drain / stall / reset sequences.
module tb_char_draw_scheduler;

    localparam int DEPTH = 16;

    logic       clock;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_char, req1_char;
    logic [8:0] req0_x, req1_x, req0_y, req1_y;
    logic       req0_ready, req1_ready;
    logic       stack_push, stack_pop;
    logic [7:0] stack_char, stack_char_out;
    logic [8:0] stack_x, stack_y, stack_x_out, stack_y_out;
    logic       stack_empty, stack_full;
    logic       frame_start, draw_valid, draw_ready;
    logic [7:0] draw_char;
    logic [8:0] draw_x, draw_y;
    logic       busy, frame_overrun;

    logic       force_full;
    int         n_tests;
    int         n_fail;
    int         ov_cnt;

    // behavioural stack: registered outputs and flags
    logic [25:0] mem [DEPTH];
    int          cnt;

    char_draw_scheduler #(.CHAR_ID_WIDTH(8), .X_WIDTH(9), .Y_WIDTH(9)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_char(req0_char), .req0_x(req0_x), .req0_y(req0_y), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_char(req1_char), .req1_x(req1_x), .req1_y(req1_y), .req1_ready(req1_ready),
        .stack_push(stack_push), .stack_char(stack_char), .stack_x(stack_x), .stack_y(stack_y),
        .stack_pop(stack_pop), .stack_char_out(stack_char_out), .stack_x_out(stack_x_out), .stack_y_out(stack_y_out),
        .stack_empty(stack_empty), .stack_full(stack_full),
        .frame_start(frame_start), .draw_valid(draw_valid), .draw_ready(draw_ready),
        .draw_char(draw_char), .draw_x(draw_x), .draw_y(draw_y),
        .busy(busy), .frame_overrun(frame_overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        cnt            = 0;
        stack_char_out = 8'd0;
        stack_x_out    = 9'd0;
        stack_y_out    = 9'd0;
    end

    // stack model update
    always @(posedge clock) begin
        if (stack_push && cnt < DEPTH) begin
            mem[cnt] <= {stack_char, stack_x, stack_y};
            cnt      <= cnt + 1;
        end else if (stack_pop && cnt > 0) begin
            {stack_char_out, stack_x_out, stack_y_out} <= mem[cnt-1];
            cnt <= cnt - 1;
        end
    end

    assign stack_empty = (cnt == 0);
    assign stack_full  = (cnt >= DEPTH) | force_full;

    typedef struct {
        logic       r0v;
        logic       r1v;
        logic       full;
        logic       e_r0rdy;
        logic       e_r1rdy;
        logic       e_push;
        logic [7:0] e_char;
        logic [8:0] e_x;
    } vec_t;

    vec_t       vt [10];
    logic [7:0] dexp [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        adv();
        adv();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0; n_fail = 0; ov_cnt = 0;
        force_full = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_char = 8'd0; req1_char = 8'd0;
        req0_x = 9'd0; req1_x = 9'd0; req0_y = 9'd0; req1_y = 9'd0;
        frame_start = 1'b0; draw_ready = 1'b0;

        // vector table: data of vector i is req0 = (0x10+i, x=i), req1 = (0x20+i, x=100+i)
        vt[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 9'd0};
        vt[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h21, 9'd101};
        vt[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 9'd2};
        vt[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h23, 9'd103};
        vt[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 9'd0};
        vt[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h25, 9'd105};
        vt[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h16, 9'd6};
        vt[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 9'd0};
        vt[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 9'd0};
        vt[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h19, 9'd9};
        dexp = '{8'h19, 8'h16, 8'h25, 8'h23, 8'h12, 8'h21, 8'h10};

        // ---- reset state
        reset = 1'b1;
        adv(); adv();
        #3;
        chk("rst_busy", busy, 1'b0);
        chk("rst_draw_valid", draw_valid, 1'b0);
        chk("rst_pop", stack_pop, 1'b0);
        chk("rst_push", stack_push, 1'b0);
        chk("rst_overrun", frame_overrun, 1'b0);
        chk("rst_draw_char", draw_char, 8'h00);
        reset = 1'b0;
        adv();

        // ---- single push then drain, latency check
        req0_valid = 1'b1; req0_char = 8'h41; req0_x = 9'd10; req0_y = 9'd20;
        #3;
        chk("t1_r0_ready", req0_ready, 1'b1);
        chk("t1_push", stack_push, 1'b1);
        chk("t1_push_char", stack_char, 8'h41);
        adv();
        req0_valid = 1'b0; frame_start = 1'b1; draw_ready = 1'b1;
        #3;
        chk("t1_fs_pop", stack_pop, 1'b0);
        chk("t1_fs_busy", busy, 1'b0);
        adv();
        frame_start = 1'b0;
        #3;
        chk("t1_pop", stack_pop, 1'b1);
        chk("t1_busy", busy, 1'b1);
        adv();
        #3;
        chk("t1_wait_pop", stack_pop, 1'b0);
        chk("t1_wait_dv", draw_valid, 1'b0);
        adv();
        #3;
        chk("t1_dv", draw_valid, 1'b1);
        chk("t1_char", draw_char, 8'h41);
        chk("t1_x", draw_x, 9'd10);
        chk("t1_y", draw_y, 9'd20);
        adv();
        #3;
        chk("t1_done_busy", busy, 1'b0);
        chk("t1_done_dv", draw_valid, 1'b0);
        draw_ready = 1'b0;

        // ---- arbitration table
        do_reset();
        for (int i = 0; i < 10; i++) begin
            req0_valid = vt[i].r0v; req1_valid = vt[i].r1v; force_full = vt[i].full;
            req0_char = 8'h10 + 8'(i); req0_x = 9'(i);       req0_y = 9'd50 + 9'(i);
            req1_char = 8'h20 + 8'(i); req1_x = 9'd100 + 9'(i); req1_y = 9'd150 + 9'(i);
            #3;
            chk($sformatf("vec%0d_r0_ready", i), req0_ready, vt[i].e_r0rdy);
            chk($sformatf("vec%0d_r1_ready", i), req1_ready, vt[i].e_r1rdy);
            chk($sformatf("vec%0d_push", i), stack_push, vt[i].e_push);
            chk($sformatf("vec%0d_pop", i), stack_pop, 1'b0);
            if (vt[i].e_push) begin
                chk($sformatf("vec%0d_char", i), stack_char, vt[i].e_char);
                chk($sformatf("vec%0d_x", i), stack_x, vt[i].e_x);
            end
            adv();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; force_full = 1'b0;

        // ---- LIFO drain of the seven table entries, 3 cycles each
        frame_start = 1'b1; draw_ready = 1'b1;
        #3;
        adv();
        frame_start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            #3;
            chk($sformatf("drain%0d_pop", k), stack_pop, 1'b1);
            adv();
            #3;
            adv();
            #3;
            chk($sformatf("drain%0d_dv", k), draw_valid, 1'b1);
            chk($sformatf("drain%0d_char", k), draw_char, dexp[k]);
            adv();
        end
        #3;
        chk("drain_idle", busy, 1'b0);

        // ---- stall with draw_ready=0, overrun pulse
        draw_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            req0_valid = 1'b1; req0_char = 8'(k); req0_x = 9'(k); req0_y = 9'(k);
            #3;
            chk($sformatf("st_push%0d", k), stack_push, 1'b1);
            adv();
        end
        req0_valid = 1'b0;
        frame_start = 1'b1;
        #3;
        adv();
        frame_start = 1'b0;
        adv();
        adv();
        req0_valid = 1'b1; req0_char = 8'h77;
        for (int j = 0; j < 5; j++) begin
            frame_start = (j == 2) ? 1'b1 : 1'b0;
            #3;
            chk($sformatf("st%0d_dv", j), draw_valid, 1'b1);
            chk($sformatf("st%0d_char", j), draw_char, 8'h03);
            chk($sformatf("st%0d_pop", j), stack_pop, 1'b0);
            chk($sformatf("st%0d_r0_ready", j), req0_ready, 1'b0);
            chk($sformatf("st%0d_push", j), stack_push, 1'b0);
            if (j == 2) chk("st_overrun_pulse", frame_overrun, 1'b1);
            if (frame_overrun) ov_cnt++;
            adv();
        end
        frame_start = 1'b0;
        chk("st_overrun_count", ov_cnt, 1);
        req0_valid = 1'b0; draw_ready = 1'b1;
        #3;
        chk("st_rel_char", draw_char, 8'h03);
        adv();
        #3;
        chk("st_pop2", stack_pop, 1'b1);
        adv(); adv();
        #3;
        chk("st_char2", draw_char, 8'h02);
        adv(); adv(); adv();
        #3;
        chk("st_char1", draw_char, 8'h01);
        chk("st_dv1", draw_valid, 1'b1);
        adv();
        #3;
        chk("st_idle", busy, 1'b0);

        // ---- stack_full blocks req1
        force_full = 1'b1; req1_valid = 1'b1; req1_char = 8'h55; req1_x = 9'd5; req1_y = 9'd6;
        for (int j = 0; j < 3; j++) begin
            #3;
            chk($sformatf("full%0d_r1_ready", j), req1_ready, 1'b0);
            chk($sformatf("full%0d_push", j), stack_push, 1'b0);
            adv();
        end
        force_full = 1'b0;
        #3;
        chk("full_rel_r1_ready", req1_ready, 1'b1);
        chk("full_rel_char", stack_char, 8'h55);
        adv();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_char = 8'h66;
        #3;
        adv();
        req0_valid = 1'b0;

        // ---- async reset while in OUT, then restart the drain
        frame_start = 1'b1; draw_ready = 1'b0;
        #3;
        adv();
        frame_start = 1'b0;
        adv(); adv();
        #3;
        chk("rmid_dv_before", draw_valid, 1'b1);
        chk("rmid_char_before", draw_char, 8'h66);
        reset = 1'b1;
        #1;
        chk("rmid_dv", draw_valid, 1'b0);
        chk("rmid_busy", busy, 1'b0);
        chk("rmid_char", draw_char, 8'h00);
        adv();
        reset = 1'b0;
        frame_start = 1'b1; draw_ready = 1'b1;
        #3;
        chk("rmid_fs_pop", stack_pop, 1'b0);
        adv();
        frame_start = 1'b0;
        #3;
        chk("rmid_pop", stack_pop, 1'b1);
        adv(); adv();
        #3;
        chk("rmid_dv2", draw_valid, 1'b1);
        chk("rmid_char2", draw_char, 8'h55);
        adv();
        #3;
        chk("rmid_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
